// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel stream sink: FSM state encoding,
// default raster size and CRC-32 constants.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        SEEK_SOF = 2'd0,
        IN_LINE  = 2'd1,
        DISCARD  = 2'd2
    } sink_state_e;

    localparam int unsigned H_ACTIVE_DEF = 1024;
    localparam int unsigned V_ACTIVE_DEF = 768;

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

endpackage

// File: rtl/pixel_stream_sink_if.sv
// AXI4-Stream video beat bundle feeding the pixel sink; the master drives beats,
// the slave returns tready.
interface pixel_stream_sink_if;

    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        tvalid;
    logic        tready;

    modport master (
        output tdata, tkeep, tlast, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tuser, tvalid,
        output tready
    );

endinterface

// File: rtl/pixel_crc32.sv
// Combinational CRC-32 step over one 24-bit RGB pixel, MSB first, non-reflected.
// Only compiled when PIXEL_SINK_CRC_EN is defined.
`ifdef PIXEL_SINK_CRC_EN
module pixel_crc32
    import pixel_stream_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [23:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 23; i >= 0; i--) begin
            if (c[31] ^ data_i[5'(i)]) begin
                c = {c[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        crc_o = c;
    end

endmodule
`endif

// File: rtl/pixel_stream_sink.sv
// Video stream sink: decodes AXI-Stream pixels into (x,y)-tagged pixels, tracks framing
// errors and counts good frames. Define PIXEL_SINK_CRC_EN to add a per-frame CRC-32.
module pixel_stream_sink
    import pixel_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    pixel_stream_sink_if.slave        in_stream,
    input  logic                      sink_en,
    input  logic                      clr_err,
    output logic                      pix_valid,
    output logic [23:0]               pix_rgb,
    output logic [15:0]               pix_x,
    output logic [15:0]               pix_y,
    output logic                      frame_done,
    output logic [15:0]               frame_count,
    output logic                      err_short,
    output logic                      err_long,
    output logic                      err_sof,
    output logic [31:0]               frame_crc
);

    // state    | meaning
    // SEEK_SOF | idle between frames; beats dropped until one carries tuser
    // IN_LINE  | inside a line; every accepted beat becomes a pixel
    // DISCARD  | line overran H_ACTIVE; beats dropped until tlast

    localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

    sink_state_e state_q, state_d, cur_state;
    logic [15:0] x_q, x_d, y_q, y_d, cur_x, cur_y;
    logic        frame_err_q, frame_err_d, cur_err;
    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        err_short_q, err_short_d, err_long_q, err_long_d, err_sof_q, err_sof_d;
    logic        accept, emit, line_end, frame_end;
    logic        set_short, set_long, set_sof;
    logic [23:0] pix_data;
    logic        unused_in;

    assign in_stream.tready = sink_en;
    assign accept           = in_stream.tvalid & sink_en;
    assign pix_data         = in_stream.tdata[23:0];
    assign unused_in        = ^{in_stream.tkeep, in_stream.tdata[31:24]};

    always_comb begin
        cur_state     = state_q;
        cur_x         = x_q;
        cur_y         = y_q;
        cur_err       = frame_err_q;
        emit          = 1'b0;
        line_end      = 1'b0;
        frame_end     = 1'b0;
        set_short     = 1'b0;
        set_long      = 1'b0;
        set_sof       = 1'b0;
        pix_valid_d   = 1'b0;
        pix_rgb_d     = pix_rgb_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;

        // A tuser beat always starts a fresh frame; mid-frame it taints the new one.
        if (accept && in_stream.tuser) begin
            set_sof   = (state_q != SEEK_SOF);
            cur_state = IN_LINE;
            cur_x     = '0;
            cur_y     = '0;
            cur_err   = set_sof;
        end

        state_d = cur_state;
        x_d     = cur_x;
        y_d     = cur_y;

        if (accept) begin
            case (cur_state)
                IN_LINE: begin
                    emit = 1'b1;
                    if (in_stream.tlast) begin
                        set_short = (cur_x != X_LAST);
                        line_end  = 1'b1;
                    end else if (cur_x == X_LAST) begin
                        set_long = 1'b1;
                        state_d  = DISCARD;
                    end else begin
                        x_d = cur_x + 16'd1;
                    end
                end
                DISCARD:  line_end = in_stream.tlast;
                default:  ;
            endcase
        end

        frame_err_d = cur_err | set_short | set_long;

        if (line_end) begin
            x_d = '0;
            if (cur_y == Y_LAST) begin
                frame_end = 1'b1;
                state_d   = SEEK_SOF;
                y_d       = '0;
                if (!frame_err_d) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end
            end else begin
                y_d     = cur_y + 16'd1;
                state_d = IN_LINE;
            end
        end

        if (emit) begin
            pix_valid_d = 1'b1;
            pix_rgb_d   = pix_data;
            pix_x_d     = cur_x;
            pix_y_d     = cur_y;
        end

        // A new error event outranks a same-cycle clear.
        err_short_d = set_short | (err_short_q & ~clr_err);
        err_long_d  = set_long  | (err_long_q  & ~clr_err);
        err_sof_d   = set_sof   | (err_sof_q   & ~clr_err);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= SEEK_SOF;
            x_q           <= '0;
            y_q           <= '0;
            frame_err_q   <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_rgb_q     <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_sof_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            frame_err_q   <= frame_err_d;
            pix_valid_q   <= pix_valid_d;
            pix_rgb_q     <= pix_rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_short_q   <= err_short_d;
            err_long_q    <= err_long_d;
            err_sof_q     <= err_sof_d;
        end
    end

`ifdef PIXEL_SINK_CRC_EN
    logic [31:0] crc_q, crc_d, crc_seed, crc_upd;
    logic [31:0] frame_crc_q, frame_crc_d;

    assign crc_seed = (accept && in_stream.tuser) ? CRC_INIT : crc_q;

    pixel_crc32 u_crc (
        .crc_i  (crc_seed),
        .data_i (pix_data),
        .crc_o  (crc_upd)
    );

    always_comb begin
        crc_d       = emit ? crc_upd : crc_seed;
        frame_crc_d = frame_crc_q;
        if (frame_end) begin
            frame_crc_d = crc_d ^ CRC_XOROUT;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            crc_q       <= CRC_INIT;
            frame_crc_q <= '0;
        end else begin
            crc_q       <= crc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
    assign frame_crc        = '0;
`endif

    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign err_sof     = err_sof_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Bench for pixel_stream_sink on a 4x3 raster: directed framing scenarios checked
// every cycle against a frame-level reference model.
module tb_pixel_stream_sink;

    localparam int H = 4;
    localparam int V = 3;

    typedef struct packed {
        logic        valid;
        logic [23:0] rgb;
        logic [15:0] x;
        logic [15:0] y;
        logic        done;
        logic [15:0] count;
        logic        es;
        logic        el;
        logic        esof;
        logic [31:0] crc;
    } exp_t;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b1;
    logic        sink_en = 1'b0;
    logic        clr_err = 1'b0;
    logic        pix_valid, frame_done, err_short, err_long, err_sof;
    logic [23:0] pix_rgb;
    logic [15:0] pix_x, pix_y, frame_count;
    logic [31:0] frame_crc;

    pixel_stream_sink_if s_if ();

    pixel_stream_sink #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .in_stream   (s_if),
        .sink_en     (sink_en),
        .clr_err     (clr_err),
        .pix_valid   (pix_valid),
        .pix_rgb     (pix_rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_sof     (err_sof),
        .frame_crc   (frame_crc)
    );

    always #5 aclk = ~aclk;

    int          n_total = 0;
    int          n_pass  = 0;
    bit          chk_en  = 1'b0;
    exp_t        e_cur, e_nxt;
    int          obs_pix, obs_done;
    logic [15:0] last_x, last_y;

    int          m_x, m_y;
    bit          m_in_frame, m_discard, m_bad;
    logic [15:0] m_count;
    bit          m_es, m_el, m_esof;
    logic [31:0] m_crc;
    logic [23:0] m_pix_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    function automatic logic [31:0] crc_of(input logic [23:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            for (int b = 23; b >= 0; b--) begin
                bit fb = c[31] ^ q[i][b];
                c = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0;
        m_in_frame = 0; m_discard = 0; m_bad = 0;
        m_count = '0; m_es = 0; m_el = 0; m_esof = 0; m_crc = '0;
        m_pix_q.delete();
        e_nxt = '0;
    endtask

    // Frame-level reference: position within the raster plus frame health.
    task automatic model_step(input bit acc, input logic [23:0] d, input bit l, input bit u, input bit c);
        bit s_sh = 0, s_lo = 0, s_so = 0, eol = 0;
        e_nxt.valid = 0;
        e_nxt.done  = 0;
        if (acc) begin
            if (u) begin
                s_so = m_in_frame;
                m_bad = m_in_frame;
                m_in_frame = 1; m_discard = 0; m_x = 0; m_y = 0;
                m_pix_q.delete();
            end
            if (m_in_frame && !m_discard) begin
                e_nxt.valid = 1; e_nxt.rgb = d; e_nxt.x = 16'(m_x); e_nxt.y = 16'(m_y);
                m_pix_q.push_back(d);
                if (l) begin
                    s_sh = (m_x != H - 1);
                    eol = 1;
                end else if (m_x == H - 1) begin
                    s_lo = 1; m_discard = 1;
                end else begin
                    m_x++;
                end
            end else if (m_in_frame && l) begin
                eol = 1;
            end
            if (s_sh || s_lo) m_bad = 1;
            if (eol) begin
                m_x = 0; m_discard = 0;
                if (m_y == V - 1) begin
                    m_in_frame = 0;
`ifdef PIXEL_SINK_CRC_EN
                    m_crc = crc_of(m_pix_q);
`endif
                    if (!m_bad) begin
                        e_nxt.done = 1;
                        m_count = m_count + 16'd1;
                    end
                end else begin
                    m_y++;
                end
            end
        end
        m_es   = s_sh | (m_es & !c);
        m_el   = s_lo | (m_el & !c);
        m_esof = s_so | (m_esof & !c);
        e_nxt.count = m_count; e_nxt.es = m_es; e_nxt.el = m_el; e_nxt.esof = m_esof;
        e_nxt.crc = m_crc;
    endtask

    task automatic beat(input bit v, input bit en, input logic [23:0] d, input bit l, input bit u, input bit c);
        s_if.tvalid = v; s_if.tdata = {8'h00, d}; s_if.tkeep = 4'hF;
        s_if.tlast = l; s_if.tuser = u;
        sink_en = en; clr_err = c;
        model_step(v && en, d, l, u, c);
        @(posedge aclk);
        #1;
        e_cur = e_nxt;
    endtask

    task automatic idle();
        beat(1'b0, 1'b1, 24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input logic [23:0] base, input logic [23:0] step);
        for (int i = 0; i < H * V; i++)
            beat(1'b1, 1'b1, base + 24'(i) * step, (i % H) == H - 1, i == 0, 1'b0);
    endtask

    task automatic pulse_reset();
        s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0; s_if.tuser = 0;
        sink_en = 0; clr_err = 0;
        aresetn = 1'b0;
        model_reset();
        e_cur = '0;
        chk_en = 1'b1;
        #1;
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_errors", 32'({err_short, err_long, err_sof}), 0);
        check("rst_frame_crc", frame_crc, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        obs_pix = 0; obs_done = 0;
    endtask

    always @(negedge aclk) begin
        if (chk_en) begin
            check("tready", 32'(s_if.tready), 32'(sink_en));
            check("pix_valid", 32'(pix_valid), 32'(e_cur.valid));
            if (e_cur.valid) begin
                check("pix_rgb", 32'(pix_rgb), 32'(e_cur.rgb));
                check("pix_x", 32'(pix_x), 32'(e_cur.x));
                check("pix_y", 32'(pix_y), 32'(e_cur.y));
            end
            check("frame_done", 32'(frame_done), 32'(e_cur.done));
            check("frame_count", 32'(frame_count), 32'(e_cur.count));
            check("err_short", 32'(err_short), 32'(e_cur.es));
            check("err_long", 32'(err_long), 32'(e_cur.el));
            check("err_sof", 32'(err_sof), 32'(e_cur.esof));
            check("frame_crc", frame_crc, e_cur.crc);
            if (pix_valid) begin
                obs_pix++;
                last_x = pix_x;
                last_y = pix_y;
            end
            if (frame_done) obs_done++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] pin_q[$];
        logic [23:0] zero_q[$];

        // CRC-32/BZIP2 check value of "123456789" pins the reference CRC routine.
        pin_q = '{24'h313233, 24'h343536, 24'h373839};
        check("crc_model_pin", crc_of(pin_q), 32'hFC891918);

        #2;
        pulse_reset();

        // Well-formed frame with a two-cycle sink_en stall in line 1.
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                beat(1'b1, 1'b0, 24'hDEAD00, 1'b0, 1'b0, 1'b0);
                beat(1'b1, 1'b0, 24'hDEAD01, 1'b0, 1'b0, 1'b0);
            end
            beat(1'b1, 1'b1, 24'h102030 + 24'(i) * 24'h010101, (i % 4) == 3, i == 0, 1'b0);
        end
        idle();
        check("s1_pix_count", obs_pix, 12);
        check("s1_done_count", obs_done, 1);
        check("s1_frame_count", 32'(frame_count), 1);
        check("s1_last_x", 32'(last_x), 3);
        check("s1_last_y", 32'(last_y), 2);
        check("s1_errors", 32'({err_short, err_long, err_sof}), 0);
        check("s1_model_count", 32'(m_count), 1);

        // Beats before the first tuser are dropped.
        pulse_reset();
        for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 24'hAAAA00 + 24'(i), i == 2, 1'b0, 1'b0);
        frame(24'h400000, 24'h000011);
        idle();
        check("s2_pix_count", obs_pix, 12);
        check("s2_done_count", obs_done, 1);
        check("s2_frame_count", 32'(frame_count), 1);

        // Short line 0, then clear, then clear colliding with a new short line.
        pulse_reset();
        beat(1'b1, 1'b1, 24'hA00000, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 24'hA00001, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 24'hA00002, 1'b1, 1'b0, 1'b0);
        idle();
        check("s3_err_short", 32'(err_short), 1);
        beat(1'b1, 1'b1, 24'hA00010, 1'b0, 1'b0, 1'b0);
        idle();
        check("s3_line1_x", 32'(last_x), 0);
        check("s3_line1_y", 32'(last_y), 1);
        for (int i = 1; i < 8; i++) beat(1'b1, 1'b1, 24'hA00010 + 24'(i), (i % 4) == 3, 1'b0, 1'b0);
        idle();
        check("s3_pix_count", obs_pix, 11);
        check("s3_done_count", obs_done, 0);
        check("s3_frame_count", 32'(frame_count), 0);
        beat(1'b0, 1'b1, 24'h0, 1'b0, 1'b0, 1'b1);
        idle();
        check("s3_cleared", 32'(err_short), 0);
        beat(1'b1, 1'b1, 24'hB00000, 1'b0, 1'b1, 1'b0);
        beat(1'b1, 1'b1, 24'hB00001, 1'b1, 1'b0, 1'b1);
        idle();
        check("s3_set_wins", 32'(err_short), 1);

        // Overlong line 0: beats 4-5 dropped, next beat lands on line 1.
        pulse_reset();
        for (int k = 0; k < 6; k++) beat(1'b1, 1'b1, 24'hC00000 + 24'(k), k == 5, k == 0, 1'b0);
        beat(1'b1, 1'b1, 24'hC00006, 1'b0, 1'b0, 1'b0);
        idle();
        check("s4_err_long", 32'(err_long), 1);
        check("s4_pix_count", obs_pix, 5);
        check("s4_next_x", 32'(last_x), 0);
        check("s4_next_y", 32'(last_y), 1);

        // Unexpected tuser on beat 6 restarts the frame but suppresses frame_done.
        pulse_reset();
        for (int k = 0; k < 6; k++) beat(1'b1, 1'b1, 24'hD00000 + 24'(k), k == 3, k == 0, 1'b0);
        frame(24'hE00000, 24'h000101);
        idle();
        check("s5_err_sof", 32'(err_sof), 1);
        check("s5_pix_count", obs_pix, 18);
        check("s5_done_count", obs_done, 0);
        check("s5_frame_count", 32'(frame_count), 0);
        check("s5_last_x", 32'(last_x), 3);
        check("s5_last_y", 32'(last_y), 2);

        // All-black frame CRC, then reset mid-frame and recovery at the next tuser.
        pulse_reset();
        frame(24'h000000, 24'h000000);
        idle();
        check("s6_frame_count", 32'(frame_count), 1);
        for (int i = 0; i < 12; i++) zero_q.push_back(24'h000000);
`ifdef PIXEL_SINK_CRC_EN
        check("s6_frame_crc", frame_crc, crc_of(zero_q));
`else
        check("s6_frame_crc", frame_crc, 0);
`endif
        for (int k = 0; k < 5; k++) beat(1'b1, 1'b1, 24'hF00000 + 24'(k), k == 3, k == 0, 1'b0);
        pulse_reset();
        for (int k = 0; k < 3; k++) beat(1'b1, 1'b1, 24'h123456, k == 2, 1'b0, 1'b0);
        check("s6_dropped", obs_pix, 0);
        frame(24'h0A0B0C, 24'h010000);
        idle();
        check("s6_pix_count", obs_pix, 12);
        check("s6_recover_count", 32'(frame_count), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
